// File: rtl/booth_controller.sv
// ---------------------------------------------------------------------------
// booth_controller
//
// Control FSM for a 4-bit radix-2 Booth multiplier datapath. A start request
// in IDLE launches a multiply. The FSM then steps the datapath through its
// iterations (LOAD, then WAIT/EVAL/[ADD|SUB]/SHIFT per iteration) and reports
// completion with busy/done.
//
// Optional feature macro: BOOTH_CTRL_ACK_EN
//   defined   : an `ack` input exists. DONE holds `done` until `ack` is seen.
//   undefined : `done` is a one-cycle pulse and DONE returns to IDLE at once.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   synchronous active-high reset (forces IDLE)
//   start            in   multiply request, sampled only in IDLE
//   q0, qm1          in   registered Booth pair Q[0], Q[-1] from the datapath
//   eqz              in   datapath iteration counter == 0
//   ack              in   result consumed (only with BOOTH_CTRL_ACK_EN)
//   ldA/clrA/sftA    out  accumulator load / clear / arithmetic shift right
//   ldQ/clrQ/sftQ    out  multiplier load / clear (tied 0) / shift
//   ldM              out  multiplicand load
//   clrff/enf        out  Q[-1] flop clear / enable
//   add_sub          out  ALU select, 1 = A+M, 0 = A-M
//   ldC/dec          out  iteration counter load / decrement
//   busy             out  high in every state except IDLE
//   done             out  result valid on the datapath output
// ---------------------------------------------------------------------------
module booth_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
`ifdef BOOTH_CTRL_ACK_EN
  input  logic ack,
`endif
  output logic ldA,
  output logic clrA,
  output logic sftA,
  output logic ldQ,
  output logic clrQ,
  output logic sftQ,
  output logic ldM,
  output logic clrff,
  output logic enf,
  output logic add_sub,
  output logic ldC,
  output logic dec,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_ADD   = 3'd4,
    S_SUB   = 3'd5,
    S_SHIFT = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state_reg;
  state_t state_next;

  // The multiplier register is never cleared, only loaded.
  assign clrQ = 1'b0;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD:  state_next = S_WAIT;
      // WAIT lets the freshly loaded/shifted Q[0], Q[-1] and the
      // decremented counter settle before EVAL looks at them.
      S_WAIT:  state_next = S_EVAL;
      S_EVAL: begin
        // Counter exhaustion wins over the Booth pair.
        if (eqz) begin
          state_next = S_DONE;
        end else begin
          unique case ({q0, qm1})
            2'b10:   state_next = S_SUB;
            2'b01:   state_next = S_ADD;
            default: state_next = S_SHIFT;
          endcase
        end
      end
      S_ADD:   state_next = S_SHIFT;
      S_SUB:   state_next = S_SHIFT;
      S_SHIFT: state_next = S_WAIT;
      S_DONE: begin
`ifdef BOOTH_CTRL_ACK_EN
        if (ack) state_next = S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus registered Moore outputs. The outputs are decoded
  // from state_next, so each output register always matches the state
  // register that is loaded on the same edge. There is no extra latency and
  // the outputs are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      ldA       <= 1'b0;
      clrA      <= 1'b0;
      sftA      <= 1'b0;
      ldQ       <= 1'b0;
      sftQ      <= 1'b0;
      ldM       <= 1'b0;
      clrff     <= 1'b0;
      enf       <= 1'b0;
      add_sub   <= 1'b0;
      ldC       <= 1'b0;
      dec       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;

      ldA       <= 1'b0;
      clrA      <= 1'b0;
      sftA      <= 1'b0;
      ldQ       <= 1'b0;
      sftQ      <= 1'b0;
      ldM       <= 1'b0;
      clrff     <= 1'b0;
      enf       <= 1'b0;
      add_sub   <= 1'b0;
      ldC       <= 1'b0;
      dec       <= 1'b0;
      busy      <= (state_next != S_IDLE);
      done      <= 1'b0;

      unique case (state_next)
        S_LOAD: begin
          ldM   <= 1'b1;
          ldQ   <= 1'b1;
          clrA  <= 1'b1;
          clrff <= 1'b1;
          ldC   <= 1'b1;
        end
        S_ADD: begin
          ldA     <= 1'b1;
          add_sub <= 1'b1;
        end
        S_SUB: begin
          ldA     <= 1'b1;
          add_sub <= 1'b0;
        end
        S_SHIFT: begin
          sftA <= 1'b1;
          sftQ <= 1'b1;
          enf  <= 1'b1;
          dec  <= 1'b1;
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          // IDLE, WAIT and EVAL assert no strobes.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_controller.sv
// ---------------------------------------------------------------------------
// tb_booth_controller
//
// Directed bench for booth_controller. A small behavioural model of the
// 4-bit Booth datapath closes the loop, so products can be compared with
// hand-computed values. The bench exercises the ack path when
// BOOTH_CTRL_ACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst, start, q0, qm1, eqz;
  logic ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, enf, add_sub, ldC, dec;
  logic busy, done;
`ifdef BOOTH_CTRL_ACK_EN
  logic ack;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_controller dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1), .eqz(eqz),
`ifdef BOOTH_CTRL_ACK_EN
    .ack(ack),
`endif
    .ldA(ldA), .clrA(clrA), .sftA(sftA), .ldQ(ldQ), .clrQ(clrQ),
    .sftQ(sftQ), .ldM(ldM), .clrff(clrff), .enf(enf), .add_sub(add_sub),
    .ldC(ldC), .dec(dec), .busy(busy), .done(done)
  );

  // Behavioural datapath: A, Q, Q[-1], M and the iteration counter.
  logic [3:0] m_in = '0, q_in = '0;
  logic [3:0] a_r = '0, q_r = '0, m_r = '0;
  logic       qm1_r = 1'b0;
  logic [2:0] cnt_r = '0;
  logic [7:0] data_out;

  always @(posedge clk) begin
    if (ldM)   m_r <= m_in;
    if (ldQ)   q_r <= q_in;
    if (clrA)  a_r <= '0;
    if (ldA)   a_r <= add_sub ? (a_r + m_r) : (a_r - m_r);
    if (sftA)  a_r <= {a_r[3], a_r[3:1]};
    if (sftQ)  q_r <= {a_r[0], q_r[3:1]};
    if (clrff) qm1_r <= 1'b0;
    if (enf)   qm1_r <= q_r[0];
    if (ldC)   cnt_r <= 3'd4;
    if (dec)   cnt_r <= cnt_r - 3'd1;
  end

  assign q0       = q_r[0];
  assign qm1      = qm1_r;
  assign eqz      = (cnt_r == 3'd0);
  assign data_out = {a_r, q_r};

  wire [13:0] all_out = {ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, enf,
                         add_sub, ldC, dec, busy, done};

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One multiply from an idle controller. The cycle in which start is
  // sampled is cycle 0. DONE is expected at cycle 16 + k.
  task automatic run_mult(input logic [3:0] m, input logic [3:0] q,
                          input int exp_k, input logic [7:0] exp_p);
    int done_cyc;
    int k;
    done_cyc = -1;
    k = 0;
    @(posedge clk); #1;
    m_in = m; q_in = q; start = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1)
        check("load_strobes", int'({ldM, ldQ, clrA, clrff, ldC, busy, ldA}),
              int'(7'b1111110));
      if (ldA) k++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_cycle", done_cyc, 16 + exp_k);
    check("addsub_count", k, exp_k);
    check("product", int'(data_out), int'(exp_p));
    $display("mult M=%0d Q=%b done_cyc=%0d k=%0d prod=%02h", m, q, done_cyc, k,
             data_out);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_after_done", int'({busy, done}), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
`ifdef BOOTH_CTRL_ACK_EN
    ack = 1'b1;
`endif
    // Reset for two cycles, then idle with start low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'(all_out), 0);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_outputs", int'(all_out), 0);
    end

    // Q = 0: shifts only, product 0.
    run_mult(4'd3, 4'd0, 0, 8'd0);
    // 3 * 5: SUB, ADD, SUB, ADD.
    run_mult(4'd3, 4'b0101, 4, 8'd15);
    // 7 * -1: a single SUB.
    run_mult(4'd7, 4'b1111, 1, 8'hF9);

    // Reset asserted in cycle 7 of a 3 * 5 run.
    @(posedge clk); #1;
    m_in = 4'd3; q_in = 4'b0101; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_c8", int'(all_out), 0);
    @(negedge clk);
    check("midrun_reset_c9", int'(all_out), 0);
    run_mult(4'd3, 4'b0101, 4, 8'd15);

`ifdef BOOTH_CTRL_ACK_EN
    // Held done: 2 * 3, with ack low for 5 cycles after DONE entry.
    begin
      int done_cyc;
      int hi;
      done_cyc = -1;
      hi = 0;
      ack = 1'b0;
      @(posedge clk); #1;
      m_in = 4'd2; q_in = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(negedge clk);
        if (done) begin
          done_cyc = cyc;
          break;
        end
        @(posedge clk); #1;
      end
      check("ack_done_cycle", done_cyc, 18);
      if (done) hi = 1;
      for (int j = 1; j <= 5; j++) begin
        @(posedge clk); #1;
        if (j == 5) ack = 1'b1;
        @(negedge clk);
        if (done) hi++;
      end
      check("ack_done_width", hi, 6);
      check("ack_product", int'(data_out), 6);
      $display("mult M=2 Q=0011 ack-held done_cyc=%0d width=%0d prod=%02h",
               done_cyc, hi, data_out);
      @(posedge clk); #1;
      @(negedge clk);
      check("ack_done_fall", int'({busy, done}), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
